// File: rtl/placar_bcd.sv
// placar_bcd: game score register plus a sequential double-dabble converter.
// The score is updated on control pulses. Every accepted update flags a
// pending conversion. The FSM turns the score into three BCD digits in
// 10 cycles and publishes all three digits together.
// Optional build macro: PLACAR_BLANK_ZEROS_EN replaces leading zero digits
// with the blank code 4'hF when the digits are published.
module placar_bcd #(
   parameter int PONTOS_INICIAIS = 100,
   parameter int PENALIDADE      = 10,
   parameter int BONUS           = 5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       zeraPontos,
   input  logic       contaErro,
   input  logic       contaAcerto,
   output logic [7:0] pontos,
   output logic [3:0] hundreds,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       ocupado,
   output logic       bcd_valido
);

   typedef enum logic [1:0] {OCIOSO, DESLOCA, CONCLUI} estado_t;

   localparam logic [7:0] INIT_C = 8'(PONTOS_INICIAIS);
   localparam logic [7:0] PEN_C  = 8'(PENALIDADE);
   localparam logic [8:0] BON_C  = 9'(BONUS);

   estado_t     state_q, state_d;
   logic [7:0]  pontos_q, pontos_d;
   logic        pendente_q, pendente_d;
   logic [7:0]  bin_q, bin_d;
   logic [11:0] bcd_q, bcd_d;
   logic [2:0]  iter_q, iter_d;
   logic [3:0]  hundreds_q, hundreds_d;
   logic [3:0]  tens_q, tens_d;
   logic [3:0]  ones_q, ones_d;

   logic        evento;
   logic        captura;
   logic        publica;
   logic [8:0]  soma;
   logic [11:0] bcd_aj;

   // Add-3 correction of every BCD nibble that is 5 or more, ahead of the shift
   for (genvar gi = 0; gi < 3; gi++) begin : g_add3
      assign bcd_aj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                 bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
   end

   // Next score: reload beats penalty, penalty beats bonus; one update per edge
   always_comb begin
      pontos_d = pontos_q;
      evento   = 1'b0;
      soma     = {1'b0, pontos_q} + BON_C;
      if (zeraPontos) begin
         pontos_d = INIT_C;
         evento   = 1'b1;
      end else if (contaErro) begin
         pontos_d = (pontos_q >= PEN_C) ? pontos_q - PEN_C : 8'd0;
         evento   = 1'b1;
      end else if (contaAcerto) begin
         pontos_d = soma[8] ? 8'hFF : soma[7:0];
         evento   = 1'b1;
      end
   end

   // Converter FSM next state: capture in OCIOSO, 8 shifts in DESLOCA, publish in CONCLUI
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      iter_d  = iter_q;
      captura = 1'b0;
      publica = 1'b0;
      case (state_q)
         OCIOSO: begin
            if (pendente_q) begin
               captura = 1'b1;
               bin_d   = pontos_q;
               bcd_d   = 12'd0;
               iter_d  = 3'd0;
               state_d = DESLOCA;
            end
         end
         DESLOCA: begin
            {bcd_d, bin_d} = {bcd_aj, bin_q} << 1;
            iter_d         = iter_q + 3'd1;
            if (iter_q == 3'd7) begin
               state_d = CONCLUI;
            end
         end
         CONCLUI: begin
            publica = 1'b1;
            state_d = OCIOSO;
         end
         default: state_d = OCIOSO;
      endcase
   end

   // A new event always wins over the capture clearing the pending flag
   always_comb begin
      pendente_d = evento | (pendente_q & ~captura);
   end

   // Digit outputs only change on publication, so partial results never show
   always_comb begin
      hundreds_d = hundreds_q;
      tens_d     = tens_q;
      ones_d     = ones_q;
      if (publica) begin
         hundreds_d = bcd_q[11:8];
         tens_d     = bcd_q[7:4];
         ones_d     = bcd_q[3:0];
`ifdef PLACAR_BLANK_ZEROS_EN
         if (bcd_q[11:8] == 4'd0) begin
            hundreds_d = 4'hF;
         end
         if (bcd_q[11:4] == 8'd0) begin
            tens_d = 4'hF;
         end
`endif
      end
   end

   // State registers; reset restores the initial score and requests its conversion
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= OCIOSO;
         pontos_q   <= INIT_C;
         pendente_q <= 1'b1;
         bin_q      <= 8'd0;
         bcd_q      <= 12'd0;
         iter_q     <= 3'd0;
         hundreds_q <= 4'd0;
         tens_q     <= 4'd0;
         ones_q     <= 4'd0;
      end else begin
         state_q    <= state_d;
         pontos_q   <= pontos_d;
         pendente_q <= pendente_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         iter_q     <= iter_d;
         hundreds_q <= hundreds_d;
         tens_q     <= tens_d;
         ones_q     <= ones_d;
      end
   end

   assign pontos     = pontos_q;
   assign hundreds   = hundreds_q;
   assign tens       = tens_q;
   assign ones       = ones_q;
   assign ocupado    = (state_q != OCIOSO);
   assign bcd_valido = (state_q == OCIOSO) && !pendente_q;

endmodule
